seq_shifter: RTL and testbench

Parametrised multi-mode shift unit for the datapath. It is the successor to the fixed 16-bit, 1-bit-per-op shifter. It shifts a W-bit operand by a variable amount in one of four modes (rotate right, logical left, logical right, arithmetic right) and reports the last bit shifted out. By default it shifts iteratively, one bit per cycle, under a start/busy/done handshake, so the FSM controller can sequence it like the other multi-cycle units.

---
 rtl/seq_shifter.sv | 158 +++++++++++++++
 tb/tb_seq_shifter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-mode shifter (ROR/LSL/LSR/ASR): one bit per cycle under start/busy/done, or
// single-cycle when SEQ_SHIFTER_FAST_EN is defined. Latency amt+1 (iterative) or 1 (fast).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module seq_shifter #(
    parameter int W   = 16,
    parameter int SAW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [SAW-1:0] amt,
    input  logic [W-1:0]   din,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   dout,
    output logic           cout
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cout_q, cout_d;
    logic [W-1:0]   dout_q, dout_d;

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign cout = cout_q;

`ifdef SEQ_SHIFTER_FAST_EN
    int           sh;
    int           k;
    logic [W-1:0] fast_res;
    logic         fast_cout;

    // cout is the last bit to leave; past W steps only fill bits (0 or sign) leave.
    always_comb begin
        sh        = int'(amt);
        k         = sh % W;
        fast_res  = din;
        fast_cout = 1'b0;
        case (mode)
            2'b00: begin
                fast_res  = (din >> k) | (din << (W - k));
                fast_cout = (sh != 0) && fast_res[W-1];
            end
            2'b01: begin
                fast_res  = din << sh;
                fast_cout = (sh >= 1 && sh <= W) ? |(din & (W'(1) << (W - sh))) : 1'b0;
            end
            2'b10: begin
                fast_res  = din >> sh;
                fast_cout = (sh >= 1 && sh <= W) ? |(din & (W'(1) << (sh - 1))) : 1'b0;
            end
            default: begin
                fast_res  = W'($signed(din) >>> sh);
                fast_cout = (sh == 0) ? 1'b0 :
                            (sh > W)  ? din[W-1] : |(din & (W'(1) << (sh - 1)));
            end
        endcase
    end
`else
    logic [W-1:0]   work_q, work_d;
    logic [1:0]     mode_q, mode_d;
    logic [SAW-1:0] cnt_q, cnt_d;
    logic [W:0]     stepped;

    // Returns {shifted_out_bit, new_value} for one single-bit step.
    function automatic logic [W:0] step1(input logic [W-1:0] r, input logic [1:0] m);
        case (m)
            2'b00:   return {r[0],   r[0],   r[W-1:1]};
            2'b01:   return {r[W-1], r[W-2:0], 1'b0};
            2'b10:   return {r[0],   1'b0,   r[W-1:1]};
            default: return {r[0],   r[W-1], r[W-1:1]};
        endcase
    endfunction

    assign stepped = step1(work_q, mode_q);
`endif

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        cout_d  = cout_q;
`ifndef SEQ_SHIFTER_FAST_EN
        work_d  = work_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef SEQ_SHIFTER_FAST_EN
                    state_d = DONE;
                    dout_d  = fast_res;
                    cout_d  = fast_cout;
`else
                    work_d = din;
                    mode_d = mode;
                    cnt_d  = amt;
                    if (amt == '0) begin
                        state_d = DONE;
                        dout_d  = din;
                        cout_d  = 1'b0;
                    end else begin
                        state_d = SHIFT;
                    end
`endif
                end
            end
`ifndef SEQ_SHIFTER_FAST_EN
            SHIFT: begin
                work_d = stepped[W-1:0];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SAW'(1)) begin
                    state_d = DONE;
                    dout_d  = stepped[W-1:0];
                    cout_d  = stepped[W];
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            cout_q  <= 1'b0;
`ifndef SEQ_SHIFTER_FAST_EN
            work_q  <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
`ifndef SEQ_SHIFTER_FAST_EN
            work_q  <= work_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter (W=16, SAW=5): directed cases plus random vectors
// against an arithmetic reference model; a negedge monitor checks every done pulse.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [4:0]  amt = 5'd0;
    logic [15:0] din = 16'h0;
    logic        busy, done, cout;
    logic [15:0] dout;

    seq_shifter #(.W(16), .SAW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .amt(amt), .din(din),
        .busy(busy), .done(done), .dout(dout), .cout(cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dout;
        logic        cout;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   ncyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int lat(input int a);
`ifdef SEQ_SHIFTER_FAST_EN
        return 1;
`else
        return a + 1;
`endif
    endfunction

    // Result of a repeated single-bit shifts expressed as plain integer arithmetic.
    function automatic void ref_model(input logic [1:0] m, input logic [15:0] d, input int a,
                                      output logic [15:0] r, output logic c);
        longint v;
        int     k;
        case (m)
            2'd0: begin
                k = a % 16;
                v = longint'(d) * 65537;
                r = 16'(v >> k);
                c = (a != 0) && r[15];
            end
            2'd1: begin
                v = longint'(d) << a;
                r = 16'(v);
                c = (a != 0) && v[16];
            end
            2'd2: begin
                v = longint'(d);
                r = 16'(v >> a);
                c = (a != 0) && (((v >> (a - 1)) & 1) != 0);
            end
            default: begin
                v = longint'($signed(d));
                r = 16'(v >>> a);
                c = (a != 0) && (((v >>> (a - 1)) & 1) != 0);
            end
        endcase
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("dout", dout, mon_e.dout);
                chk("cout", cout, mon_e.cout);
                chk("latency", ncyc, mon_e.due);
            end
        end
    end

    task automatic push_exp(input logic [15:0] xd, input logic xc, input int a);
        exp_t x;
        x.dout = xd;
        x.cout = xc;
        x.due  = ncyc + lat(a);
        sbq.push_back(x);
    endtask

    task automatic run_op(input logic [1:0] m, input logic [15:0] d, input logic [4:0] a,
                          input logic [15:0] xd, input logic xc, input bit inj);
        bit seen;
        @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);
        start = 1'b1;
        mode  = m;
        din   = d;
        amt   = a;
        push_exp(xd, xc, int'(a));
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = done;
            if (i == 0) chk("busy_after_start", busy, 1);
            #1;
            din   = 16'($urandom);
            mode  = 2'($urandom);
            amt   = 5'($urandom);
            start = !seen && inj && busy && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        if (!seen) begin
            chk("done_timeout", 0, 1);
            sbq.delete();
        end
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] d;
        logic [4:0]  a;
        logic [15:0] xd;
        logic        xc;
    } vec_t;

    vec_t dir[$] = '{
        '{2'd1, 16'h8001, 5'd1,  16'h0002, 1'b1},
        '{2'd3, 16'hF0F0, 5'd4,  16'hFF0F, 1'b0},
        '{2'd0, 16'h0001, 5'd1,  16'h8000, 1'b1},
        '{2'd2, 16'h8000, 5'd15, 16'h0001, 1'b0},
        '{2'd1, 16'hABCD, 5'd20, 16'h0000, 1'b0},
        '{2'd0, 16'h1234, 5'd20, 16'h4123, 1'b0},
        '{2'd0, 16'h1234, 5'd4,  16'h4123, 1'b0},
        '{2'd3, 16'h8000, 5'd20, 16'hFFFF, 1'b1},
        '{2'd2, 16'hFFFF, 5'd16, 16'h0000, 1'b1},
        '{2'd2, 16'hFFFF, 5'd17, 16'h0000, 1'b0},
        '{2'd1, 16'h0001, 5'd16, 16'h0000, 1'b1},
        '{2'd0, 16'hA5A5, 5'd16, 16'hA5A5, 1'b1},
        '{2'd3, 16'h7FFF, 5'd31, 16'h0000, 1'b0},
        '{2'd0, 16'h1234, 5'd0,  16'h1234, 1'b0},
        '{2'd1, 16'h1234, 5'd0,  16'h1234, 1'b0},
        '{2'd2, 16'h1234, 5'd0,  16'h1234, 1'b0},
        '{2'd3, 16'h1234, 5'd0,  16'h1234, 1'b0}
    };

    initial begin
        logic [1:0]  m;
        logic [15:0] d, xd;
        logic [4:0]  a;
        logic        xc;
        int          nrand;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
        chk("rst_cout", cout, 0);
        #1 reset = 1'b0;

        foreach (dir[i]) run_op(dir[i].m, dir[i].d, dir[i].a, dir[i].xd, dir[i].xc, 1'b0);

        // Second start, held while the first (amt=0) op sits in DONE, must be dropped.
        @(negedge clk);
        #1;
        start = 1'b1; mode = 2'd1; din = 16'h1234; amt = 5'd0;
        push_exp(16'h1234, 1'b0, 0);
        @(negedge clk);
        #1 din = 16'hFFFF;
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("ignored_start_dout", dout, 16'h1234);
        chk("ignored_start_busy", busy, 0);

        // Reset in the middle of an LSL by 10.
        @(negedge clk);
        #1;
        start = 1'b1; mode = 2'd1; din = 16'hC3A5; amt = 5'd10;
        ref_model(2'd1, 16'hC3A5, 10, xd, xc);
        push_exp(xd, xc, 10);
        @(negedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dout", dout, 0);
        chk("abort_cout", cout, 0);
        #1 reset = 1'b0;
        sbq.delete();
        repeat (15) @(negedge clk);
        run_op(2'd2, 16'hF00F, 5'd3, 16'h1E01, 1'b1, 1'b0);

`ifdef SEQ_SHIFTER_FAST_EN
        nrand = 1000;
`else
        nrand = 300;
`endif
        for (int n = 0; n < nrand; n++) begin
            m = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            a = 5'($urandom_range(0, 31));
            ref_model(m, d, int'(a), xd, xc);
            run_op(m, d, a, xd, xc, 1'b1);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
